// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus; one grant per transaction.
// Optional slave watchdog enabled by defining ARB_TIMEOUT_EN (TIMEOUT_CYCLES sets its limit).
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        busy_s;
    logic        timeout_s;
    logic        done_s;
    logic [31:0] rdata_s;

    if (TIMEOUT_CYCLES < 32'd2 || TIMEOUT_CYCLES > 32'd255) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    assign busy_s = (state_q == ST_BUSY);
    assign done_s = busy_s && (s_ready || timeout_s);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

    logic [7:0] cnt_q, cnt_d;

    // A stuck slave is released on the last allowed BUSY cycle; a real s_ready takes priority.
    assign timeout_s = busy_s && !s_ready && (cnt_q == TO_LAST);
    assign err       = timeout_s;

    // Watchdog count: cleared while idle so every grant starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_s) begin
            cnt_d = 8'd0;
        end else if (!s_ready) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Grant selection and transaction sequencing; ties go to the master that did not win last.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = ST_BUSY;
                    owner_d = ~last_owner_q;
                end else if (m0_valid) begin
                    state_d = ST_BUSY;
                    owner_d = 1'b0;
                end else if (m1_valid) begin
                    state_d = ST_BUSY;
                    owner_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers; last_owner resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign rdata_s = timeout_s ? 32'hDEAD_BEEF : s_rdata;

    assign s_valid  = busy_s;
    assign s_instr  = owner_q ? m1_instr : m0_instr;
    assign s_addr   = owner_q ? m1_addr  : m0_addr;
    assign s_wdata  = owner_q ? m1_wdata : m0_wdata;
    assign s_wstrb  = owner_q ? m1_wstrb : m0_wstrb;

    assign m0_ready = done_s && !owner_q;
    assign m1_ready = done_s && owner_q;
    assign m0_rdata = owner_q ? 32'h0000_0000 : rdata_s;
    assign m1_rdata = owner_q ? rdata_s : 32'h0000_0000;
    assign owner    = owner_q;

endmodule
